// File: rtl/range_match_pkg.sv
// rtl/range_match_pkg.sv - shared sizes, tree-index helpers and cfg_sel encodings for the range matcher
package range_match_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int NUM_NODES     = (1 << DEPTH_DEFAULT) - 1;
  localparam int NUM_LEAVES    = 1 << DEPTH_DEFAULT;

  typedef enum logic {
    CFG_BOUND = 1'b0,
    CFG_RIDS  = 1'b1
  } cfg_sel_e;

  function automatic int num_nodes(input int depth);
    return (1 << depth) - 1;
  endfunction

  function automatic int level_base(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic int child(input int n, input logic dir);
    return 2 * n + 1 + int'(dir);
  endfunction

endpackage

// File: rtl/range_match_tree_pe.sv
// rtl/range_match_tree_pe.sv - unsigned boundary comparator; equality steers right
module range_match_tree_pe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_bound,
  output logic                  o_right
);

  assign o_right = !(i_data < i_bound);

endmodule

// File: rtl/range_match_tree_pipe_stage.sv
// rtl/range_match_tree_pipe_stage.sv - one tree level: compare, append path bit, register under enable
module range_match_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LEVEL      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DEPTH-1:0]      i_path,
  input  logic [DATA_WIDTH-1:0] i_bound,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DEPTH-1:0]      o_path
);

  logic                  w_right;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DEPTH-1:0]      r_path;

  range_match_tree_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
    .i_data (i_data),
    .i_bound(i_bound),
    .o_right(w_right)
  );

  // Path is built MSB-first so the root decision lands in the leaf index MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_path  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
      r_path  <= i_path | (DEPTH'(w_right) << (DEPTH - 1 - LEVEL));
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_path  = r_path;

endmodule

// File: rtl/range_match_tree_pipe.sv
// rtl/range_match_tree_pipe.sv - pipelined binary-search range matcher with runtime boundary/RIDS tables
module range_match_tree_pipe
  import range_match_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  parameter  int RIDS_WIDTH = 32,
  localparam int CFG_WIDTH  = (DATA_WIDTH > RIDS_WIDTH) ? DATA_WIDTH : RIDS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RIDS_WIDTH-1:0] out_rids,
  output logic [DEPTH-1:0]      out_leaf,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [DEPTH-1:0]      cfg_addr,
  input  logic [CFG_WIDTH-1:0]  cfg_wdata
);

  localparam int N_NODES  = num_nodes(DEPTH);
  localparam int N_LEAVES = 1 << DEPTH;

  logic [DATA_WIDTH-1:0] r_bound [N_NODES];
  logic [RIDS_WIDTH-1:0] r_rids  [N_LEAVES];

  logic                  w_en;
  logic                  w_valid [DEPTH+1];
  logic [DATA_WIDTH-1:0] w_data  [DEPTH+1];
  logic [DEPTH-1:0]      w_path  [DEPTH+1];

  logic                  r_out_valid;
  logic [DEPTH-1:0]      r_out_leaf;
  logic [RIDS_WIDTH-1:0] r_out_rids;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_path[0]  = '0;

  // Stage l only has its top l path bits set; shifting them down gives the in-level offset.
  for (genvar l = 0; l < DEPTH; l++) begin : g_stage
    logic [DEPTH-1:0] w_node;
    assign w_node = DEPTH'(level_base(l)) + (w_path[l] >> (DEPTH - l));

    range_match_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .LEVEL     (l)
    ) u_stage (
      .i_clk  (clk),
      .i_rst_n(reset),
      .i_en   (w_en),
      .i_valid(w_valid[l]),
      .i_data (w_data[l]),
      .i_path (w_path[l]),
      .i_bound(r_bound[w_node]),
      .o_valid(w_valid[l+1]),
      .o_data (w_data[l+1]),
      .o_path (w_path[l+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_leaf  <= '0;
      r_out_rids  <= '0;
    end else if (w_en) begin
      r_out_valid <= w_valid[DEPTH];
      r_out_leaf  <= w_path[DEPTH];
      r_out_rids  <= r_rids[w_path[DEPTH]];
    end
  end

  // Table writes ignore back-pressure; lookups in the write cycle still see the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NODES; i++) r_bound[i] <= '0;
      for (int i = 0; i < N_LEAVES; i++) r_rids[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_sel == CFG_RIDS) begin
        r_rids[cfg_addr] <= cfg_wdata[RIDS_WIDTH-1:0];
      end else if (int'(cfg_addr) < N_NODES) begin
        r_bound[cfg_addr] <= cfg_wdata[DATA_WIDTH-1:0];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_leaf  = r_out_leaf;
  assign out_rids  = r_out_rids;

endmodule
